// File: rtl/alu_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : alu_seq_if
// Brief  : Operand/op input beat and result output beat of alu_seq, each
//          with its own valid/ready pair.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_sel;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_f;
   logic [WIDTH-1:0] out_f_hi;
   logic             out_cout;
   logic             out_zero;
   logic             out_neg;
   logic             out_ovf;

   // Source of operands and consumer of results.
   modport master (
      output in_valid, in_sel, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_f, out_f_hi, out_cout, out_zero,
             out_neg, out_ovf
   );

   // The ALU itself.
   modport slave (
      input  in_valid, in_sel, in_a, in_b, out_ready,
      output in_ready, out_valid, out_f, out_f_hi, out_cout, out_zero,
             out_neg, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : alu_seq
// Brief  : Handshaked WIDTH-bit ALU with registered result/flags and an
//          optional multi-cycle shift-add unsigned multiplier on op 7.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   alu_seq_if.slave    bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_f_q, out_f_d;
   logic [WIDTH-1:0]   out_f_hi_q, out_f_hi_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   // Upper half is the accumulator, lower half starts as the multiplier and
   // is shifted out one bit per step as product bits shift in from above.
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         rst_sync_q, rst_sync_d;

   logic               rst_int_n;
   logic               accept;
   logic [WIDTH:0]     a_ext, b_ext, alu_r;
   logic               alu_ovf, alu_is_mul;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;

   // Reset synchroniser: asserts with rst_n, releases two edges later.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   // Reset synchroniser register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n    = rst_sync_q[1];
   assign bus.in_ready = rst_int_n && (state_q == IDLE) &&
                         (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Single-cycle datapath, arithmetic evaluated one bit wider for carry.
   always_comb begin
      a_ext      = {1'b0, bus.in_a};
      b_ext      = {1'b0, bus.in_b};
      alu_r      = '0;
      alu_ovf    = 1'b0;
      alu_is_mul = 1'b0;
      case (bus.in_sel)
         3'd0: begin
            alu_r   = a_ext + b_ext;
            alu_ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                      (alu_r[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         3'd1: begin
            alu_r   = a_ext + {1'b0, ~bus.in_b} + {{WIDTH{1'b0}}, 1'b1};
            alu_ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                      (alu_r[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         3'd2: begin
            // The +1 operand is positive, so only a positive A can overflow.
            alu_r   = a_ext + {{WIDTH{1'b0}}, 1'b1};
            alu_ovf = !bus.in_a[WIDTH-1] && alu_r[WIDTH-1];
         end
         3'd3: begin
            // Subtracting +1: only a negative A can wrap to positive.
            alu_r   = a_ext + {1'b0, {WIDTH{1'b1}}};
            alu_ovf = bus.in_a[WIDTH-1] && !alu_r[WIDTH-1];
         end
         3'd4:    alu_r = {1'b0, bus.in_a & bus.in_b};
         3'd5:    alu_r = {1'b0, bus.in_a | bus.in_b};
         3'd6:    alu_r = {1'b0, bus.in_a ^ bus.in_b};
         default: begin
            if (MUL_EN) alu_is_mul = 1'b1;
            else        alu_r      = {1'b0, ~bus.in_a};
         end
      endcase
   end

   // FSM next state, multiplier step and output register load.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_f_d     = out_f_q;
      out_f_hi_d  = out_f_hi_q;
      cout_d      = cout_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;
      mcand_d     = mcand_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod_step   = {mul_sum, prod_q[WIDTH-1:1]};
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (alu_is_mul) begin
                  state_d = MUL_BUSY;
                  mcand_d = bus.in_a;
                  prod_d  = {{WIDTH{1'b0}}, bus.in_b};
                  cnt_d   = '0;
               end else begin
                  out_valid_d = 1'b1;
                  out_f_d     = alu_r[WIDTH-1:0];
                  out_f_hi_d  = '0;
                  cout_d      = alu_r[WIDTH];
                  zero_d      = (alu_r[WIDTH-1:0] == '0);
                  neg_d       = alu_r[WIDTH-1];
                  ovf_d       = alu_ovf;
               end
            end
         end
         MUL_BUSY: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               out_f_d     = prod_step[WIDTH-1:0];
               out_f_hi_d  = prod_step[2*WIDTH-1:WIDTH];
               cout_d      = 1'b0;
               zero_d      = (prod_step == '0);
               neg_d       = prod_step[WIDTH-1];
               ovf_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, multiplier and output registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_f_q     <= '0;
         out_f_hi_q  <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_f_q     <= out_f_d;
         out_f_hi_q  <= out_f_hi_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_f     = out_f_q;
   assign bus.out_f_hi  = out_f_hi_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_zero  = zero_q;
   assign bus.out_neg   = neg_q;
   assign bus.out_ovf   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_alu_seq
// Brief  : Directed scoreboard bench for alu_seq (WIDTH=4, MUL_EN=1).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_alu_seq;
   typedef struct {
      int         id;
      logic [3:0] f;
      logic [3:0] hi;
      logic       c, z, n, o;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;
   exp_t q[$];
   int   pop_cyc[$];

   alu_seq_if #(.WIDTH(4)) bus();

   alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Protocol check: opcode must be known whenever a beat is offered.
   always @(posedge clk) begin
      if (rst_n && bus.in_valid)
         assert (!$isunknown(bus.in_sel)) else $error("in_sel unknown with in_valid");
   end

   // Monitor: pop the scoreboard on every completed output handshake.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         tests++;
         pop_cyc.push_back(cyc);
         if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_result got f=%0d hi=%0d, required no output", bus.out_f, bus.out_f_hi);
         end else begin
            e = q.pop_front();
            if (bus.out_f !== e.f || bus.out_f_hi !== e.hi || bus.out_cout !== e.c ||
                bus.out_zero !== e.z || bus.out_neg !== e.n || bus.out_ovf !== e.o) begin
               failed++;
               $display("FAIL result id=%0d got f=%0d hi=%0d c=%0b z=%0b n=%0b o=%0b required f=%0d hi=%0d c=%0b z=%0b n=%0b o=%0b",
                        e.id, bus.out_f, bus.out_f_hi, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf,
                        e.f, e.hi, e.c, e.z, e.n, e.o);
            end
         end
      end
   end

   function automatic exp_t mk(int id, logic [3:0] f, logic [3:0] hi,
                               logic c, logic z, logic n, logic o);
      exp_t e;
      e.id = id; e.f = f; e.hi = hi; e.c = c; e.z = z; e.n = n; e.o = o;
      return e;
   endfunction

   task automatic check(string name, int got, int want);
      tests++;
      if (got != want) begin
         failed++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   // Offer one beat, push its expectation, wait (bounded) for acceptance.
   task automatic issue(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b,
                        input exp_t e, output int waits);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_a     = a;
      bus.in_b     = b;
      q.push_back(e);
      waits = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         waits++;
      end
      if (waits >= 50) begin
         tests++;
         failed++;
         $display("FAIL accept_timeout id=%0d got no in_ready required in_ready within 50 cycles", e.id);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int w, wsum, bad;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 3'd0;
      bus.in_a      = 4'd0;
      bus.in_b      = 4'd0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_outputs", int'({bus.out_f, bus.out_f_hi, bus.out_cout, bus.out_zero,
                                   bus.out_neg, bus.out_ovf}), 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("in_ready_after_reset", int'(bus.in_ready), 1);

      // Basic arithmetic
      issue(3'd0, 4'd5, 4'd3, mk(1, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), w);
      issue(3'd1, 4'd5, 4'd3, mk(2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), w);
      issue(3'd1, 4'd3, 4'd5, mk(3, 4'd14, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), w);
      repeat (2) @(posedge clk);
      #1;

      // Ops 2..6 back to back
      pop_cyc.delete();
      wsum = 0;
      issue(3'd2, 4'd5, 4'd3, mk(4, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w); wsum += w;
      issue(3'd3, 4'd5, 4'd3, mk(5, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), w); wsum += w;
      issue(3'd4, 4'd5, 4'd3, mk(6, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w); wsum += w;
      issue(3'd5, 4'd5, 4'd3, mk(7, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w); wsum += w;
      issue(3'd6, 4'd5, 4'd3, mk(8, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w); wsum += w;
      repeat (2) @(posedge clk);
      #1;
      check("burst_stall_cycles", wsum, 0);
      check("burst_result_count", pop_cyc.size(), 5);
      bad = 0;
      for (int i = 1; i < pop_cyc.size(); i++)
         if (pop_cyc[i] != pop_cyc[i-1] + 1) bad++;
      check("burst_consecutive_gaps", bad, 0);

      // Boundaries: zero result, DEC of 0, signed overflow on INC/DEC
      issue(3'd6, 4'd9, 4'd9, mk(9, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0), w);
      issue(3'd3, 4'd0, 4'd0, mk(10, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), w);
      issue(3'd2, 4'd7, 4'd0, mk(11, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), w);
      issue(3'd3, 4'd8, 4'd0, mk(12, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1), w);
      repeat (2) @(posedge clk);
      #1;

      // MUL latency and results
      issue(3'd7, 4'd5, 4'd3, mk(13, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), w);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.in_ready || bus.out_valid) bad++;
      end
      check("mul_busy_cycles", bad, 0);
      @(negedge clk);
      check("mul_valid_after_width", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      issue(3'd7, 4'd15, 4'd15, mk(14, 4'd1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0), w);
      repeat (6) @(posedge clk);
      #1;
      issue(3'd7, 4'd0, 4'd9, mk(15, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0), w);
      repeat (6) @(posedge clk);
      #1;

      // Backpressure: hold ADD 2+3, then drain while a SUB is pending
      bus.out_ready = 1'b0;
      issue(3'd0, 4'd2, 4'd3, mk(16, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_f !== 4'd5 || bus.out_cout !== 1'b0 ||
             bus.out_zero !== 1'b0 || bus.out_neg !== 1'b0 || bus.out_ovf !== 1'b0 ||
             bus.in_ready) bad++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'd1;
      bus.in_a     = 4'd7;
      bus.in_b     = 4'd2;
      @(negedge clk);
      if (bus.in_ready || bus.out_f !== 4'd5) bad++;
      check("backpressure_hold", bad, 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      issue(3'd1, 4'd7, 4'd2, mk(17, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), w);
      check("drain_and_accept_same_edge", w, 0);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a MUL
      issue(3'd7, 4'd7, 4'd3, mk(18, 4'd5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), w);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(q.pop_back());
      check("midmul_reset_outputs", int'({bus.out_valid, bus.out_f, bus.out_f_hi, bus.out_cout,
                                          bus.out_zero, bus.out_neg, bus.out_ovf}), 0);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.out_valid) bad++;
      end
      check("midmul_no_valid", bad, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(3'd0, 4'd1, 4'd1, mk(19, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), w);

      // Drain scoreboard with a bound
      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      #1;
      check("scoreboard_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU: WIDTH-bit operands, 3-bit op select, registered result and flags.
- Adds a multi-cycle shift-add unsigned multiplier on op 7.
- Sits between the operand/select source and any downstream consumer.
- Uses valid/ready on both sides so either side may stall.

Parameters:
- WIDTH, 4, operand/result width; legal values 2..32.
- MUL_EN, 1, 1 means op 7 is a multi-cycle MUL; 0 means op 7 is single-cycle NOT A.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op beat valid
- in_ready  output  1  block can accept a beat
- in_sel  input  3  opcode (S2,S1,S0)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_f  output  WIDTH  result (low half for MUL)
- out_f_hi  output  WIDTH  high half of MUL product; 0 for all other ops
- out_cout  output  1  carry flag
- out_zero  output  1  out_f == 0 (MUL: full 2*WIDTH product == 0)
- out_neg  output  1  out_f[WIDTH-1]
- out_ovf  output  1  signed overflow (ADD/SUB/INC/DEC only, else 0)

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=IDLE, out_valid=0, out_f=0, out_f_hi=0, all flags 0.
  - in_ready=1 once rst_n is high.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A+~B+1; cout=1 means no borrow
  - 2 INC: A+1
  - 3 DEC: A-1, computed as A+all-ones; cout=1 unless A==0
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 MUL (MUL_EN=1) or NOT A (MUL_EN=0)
- Arithmetic ops are computed at WIDTH+1 bits; cout is bit WIDTH. Logic ops and NOT force cout=0 and ovf=0.
- ovf:
  - ADD/INC: operands same sign and result sign differs.
  - SUB/DEC: operand signs differ and result sign differs from A.
- Handshake:
  - Accept on rising edge when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A single-cycle op can therefore issue back-to-back at full throughput while the consumer keeps out_ready=1.
  - The output register (out_f, out_f_hi, flags) holds stable while out_valid && !out_ready.
  - out_valid drops on the edge where out_valid && out_ready, unless a new result is loaded on that same edge.
- Latency:
  - Single-cycle ops: accepted at edge N, out_valid=1 after edge N.
  - MUL: accepted at edge N, state=MUL_BUSY; result valid after edge N+WIDTH.
- States:
  - IDLE: single-cycle ops go straight to the output register. MUL latches A into the multiplicand, B into the multiplier, clears the accumulator and bit counter, then moves to MUL_BUSY.
  - MUL_BUSY: each cycle, if the multiplier LSB is 1 add the multiplicand into the accumulator high half; shift the {carry, acc} right by one; increment the counter. On the WIDTH-th step, load out_f/out_f_hi/flags, set out_valid, return to IDLE. in_ready=0 throughout.
- MUL entry gating: MUL is only accepted when the output slot is free or being drained that cycle, which the in_ready rule guarantees.
- in_sel/in_a/in_b are ignored whenever in_valid=0 or in_ready=0.
- Reset mid-MUL: everything returns to reset values immediately. The partial product is discarded and no out_valid pulse is produced.
- Unknown/X in_sel while in_valid=1 is a protocol error; the bench asserts against it.

Test Plan:
- WIDTH=4, ADD A=5 B=3, out_ready=1 -> one cycle later out_f=8, cout=0, ovf=1, neg=1, zero=0.
- SUB A=5 B=3 -> out_f=2, cout=1, ovf=0. Then SUB A=3 B=5 -> out_f=14, cout=0, neg=1.
- Ops 2..6 with A=5 B=3 issued back-to-back, out_ready=1:
  - in_ready stays 1.
  - Results 6, 4, 1, 7, 6 appear on five consecutive cycles.
- MUL A=5 B=3 (MUL_EN=1) -> in_ready=0 for 4 cycles; out_f=15, out_f_hi=0, zero=0. MUL A=15 B=15 -> out_f=1, out_f_hi=14.
- Backpressure: ADD result held with out_ready=0 for 3 cycles -> out_f/flags stable, in_ready=0. Raise out_ready with a new beat pending -> result drained and new beat accepted on the same edge.
- Assert rst_n=0 at cycle 2 of a MUL -> out_valid stays 0, all outputs 0. After release, ADD 1+1 -> out_f=2.
